// File: rtl/fifo_sync_param_if.sv
// Handshake/bus bundle for fifo_sync_param.
// master: producer/consumer side; slave: the FIFO itself.
interface fifo_sync_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] data_in;
    logic              push;
    logic              full;
    logic              almost_full;
    logic [DATA_W-1:0] data_out;
    logic              pop;
    logic              empty;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              clr_err;
    logic              overflow;
    logic              underflow;

    modport master (
        output data_in, push, pop, clr_err,
        input  full, almost_full, data_out, empty, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  data_in, push, pop, clr_err,
        output full, almost_full, data_out, empty, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Optional macro FIFO_SYNC_FWFT_EN selects first-word-fall-through reads;
// without it data_out is a registered copy of the last popped word.
// All flags are decoded from the registered count, so push/pop never reach a
// flag combinationally.
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fifo_sync_param_if.slave   bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic full_w;
    logic empty_w;
    logic wr_acc;
    logic rd_acc;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);
    assign wr_acc  = bus.push && !full_w;
    assign rd_acc  = bus.pop && !empty_w;

    // Next-state for pointers, occupancy and sticky error flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        // a rejection in the same cycle as clr_err wins, so no event is lost
        ovf_d = (bus.push && full_w)  || (ovf_q && !bus.clr_err);
        unf_d = (bus.pop  && empty_w) || (unf_q && !bus.clr_err);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; deliberately not cleared by reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head entry is shown directly; forced to zero while empty
    always_comb begin
        bus.data_out = '0;
        if (!empty_w) begin
            bus.data_out = mem_q[rd_ptr_q];
        end
    end
`else
    logic [DATA_W-1:0] data_out_q, data_out_d;

    // Popped word is captured on the accepting edge, held otherwise
    always_comb begin
        data_out_d = data_out_q;
        if (rd_acc) begin
            data_out_d = mem_q[rd_ptr_q];
        end
    end

    // Registered read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
`endif

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
